// File: rtl/program_memory_loader.sv
// Framed byte-stream loader for the PicoBlaze program RAM write port.
// Holds the CPU in reset while a frame is received and reports done/error stickily.
module program_memory_loader #(
  parameter int          ADDRESS_WIDTH = 10,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [17:0]              write_data,
  output logic                     cpu_reset,
  output logic                     load_done,
  output logic                     load_error
);

  localparam int CW = ADDRESS_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2, S_WRITE, S_CHK, S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               sum_q, sum_d;
  logic [7:0]               cnt_hi_q, cnt_hi_d;
  logic [7:0]               b1_q, b1_d;
  logic [1:0]               b0_q, b0_d;
  logic [CW-1:0]            addr_q, addr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [17:0]              wd_q, wd_d;
  logic                     cpu_reset_q, cpu_reset_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     xfer;
  logic [31:0]              n_req;

  always_comb begin
    xfer        = byte_valid && (state_q != S_WRITE);
    n_req       = {16'd0, cnt_hi_q, byte_data};
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_hi_d    = cnt_hi_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    // Every accepted byte after SYNC contributes to the running checksum.
    if (xfer && state_q != S_IDLE && state_q != S_ERROR) begin
      sum_d = sum_q + byte_data;
    end
    case (state_q)
      S_IDLE: begin
        if (xfer && byte_data == SYNC_BYTE) begin
          state_d     = S_CNT_HI;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_reset_d = 1'b1;
          sum_d       = 8'd0;
          addr_d      = '0;
        end
      end
      S_CNT_HI: if (xfer) begin
        cnt_hi_d = byte_data;
        state_d  = S_CNT_LO;
      end
      S_CNT_LO: if (xfer) begin
        if (n_req == 32'd0 || n_req > (32'd1 << ADDRESS_WIDTH)) begin
          state_d = S_ERROR;
        end else begin
          cnt_d   = CW'(n_req);
          state_d = S_B0;
        end
      end
      S_B0: if (xfer) begin
        b0_d    = byte_data[1:0];
        state_d = S_B1;
      end
      S_B1: if (xfer) begin
        b1_d    = byte_data;
        state_d = S_B2;
      end
      S_B2: if (xfer) begin
        wa_d    = addr_q[ADDRESS_WIDTH-1:0];
        wd_d    = {b0_q, b1_q, byte_data};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d  = addr_q + CW'(1);
        state_d = (addr_d == cnt_q) ? S_CHK : S_B0;
      end
      S_CHK: if (xfer) begin
        if (sum_d == 8'd0) begin
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Frame-scoped datapath: always reloaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    sum_q    <= sum_d;
    cnt_hi_q <= cnt_hi_d;
    b0_q     <= b0_d;
    b1_q     <= b1_d;
    cnt_q    <= cnt_d;
  end

  assign byte_ready    = (state_q != S_WRITE);
  assign write_enable  = (state_q == S_WRITE);
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign cpu_reset     = cpu_reset_q;
  assign load_done     = done_q;
  assign load_error    = err_q;

endmodule
